// File: rtl/mlp_pkg.sv
// Shared types and default sizing for the MLP activation buffer.
package mlp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2,
        ST_DRAIN = 2'd3
    } mlp_buf_state_e;

    localparam int DATA_W_DEF       = 16;
    localparam int COLS_DEF         = 16;
    localparam int ROWS_PER_RND_DEF = 2;
    localparam int NUM_RND_DEF      = 8;
    localparam int OUT_LANES_DEF    = 2;

endpackage

// File: rtl/mlp_row_ram.sv
// Row storage: multi-row write per round, registered read port returning old
// data on a same-cycle collision, plus an unregistered row tap for the drain.
module mlp_row_ram #(
    parameter int DATA_W       = 16,
    parameter int COLS         = 16,
    parameter int ROWS_PER_RND = 2,
    parameter int DEPTH        = 16,
    parameter int AW           = 4,
    parameter int ROW_W        = COLS * DATA_W
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en_i,
    input  logic [AW-1:0]                   wr_base_i,
    input  logic [ROWS_PER_RND*ROW_W-1:0]   wr_rows_i,
    input  logic [AW-1:0]                   rd_row_i,
    output logic [ROW_W-1:0]                rd_data_o,
    input  logic [AW-1:0]                   dr_row_i,
    output logic [ROW_W-1:0]                dr_data_o
);

    logic [ROW_W-1:0] r_mem [DEPTH];
    logic [ROW_W-1:0] r_rd_data;

    // Contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int r = 0; r < ROWS_PER_RND; r++) begin
                r_mem[wr_base_i + AW'(r)] <= wr_rows_i[r*ROW_W +: ROW_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_rd_data <= '0;
        else        r_rd_data <= r_mem[rd_row_i];
    end

    assign rd_data_o = r_rd_data;
    assign dr_data_o = r_mem[dr_row_i];

endmodule

// File: rtl/mlp_act_buffer.sv
// Collects PE-array rounds into a layer buffer, serves next-layer row reads,
// and drains the final layer as a ready/valid beat stream.
module mlp_act_buffer
    import mlp_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int COLS         = COLS_DEF,
    parameter int ROWS_PER_RND = ROWS_PER_RND_DEF,
    parameter int NUM_RND      = NUM_RND_DEF,
    parameter int OUT_LANES    = OUT_LANES_DEF
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      wr_valid_i,
    input  logic [ROWS_PER_RND*COLS*DATA_W-1:0]       wr_rows_i,
    input  logic [$clog2(NUM_RND)-1:0]                wr_round_i,
    input  logic                                      last_layer_i,
    input  logic [$clog2(ROWS_PER_RND*NUM_RND)-1:0]   rd_row_i,
    output logic [COLS*DATA_W-1:0]                    rd_data_o,
    output logic                                      out_valid_o,
    input  logic                                      out_ready_i,
    output logic [OUT_LANES*DATA_W-1:0]               out_data_o,
    output logic                                      out_last_o,
    output logic                                      full_o,
    output logic                                      err_o
);

    localparam int DEPTH  = ROWS_PER_RND * NUM_RND;
    localparam int AW     = $clog2(DEPTH);
    localparam int BPR    = COLS / OUT_LANES;
    localparam int CW     = (BPR > 1) ? $clog2(BPR) : 1;
    localparam int BEAT_W = OUT_LANES * DATA_W;
    localparam int ROW_W  = COLS * DATA_W;

    mlp_buf_state_e     r_state, w_state_nx;
    logic [NUM_RND-1:0] r_mask,  w_mask_nx;
    logic               r_last,  w_last_nx;
    logic [AW-1:0]      r_drow,  w_drow_nx;
    logic [CW-1:0]      r_dcol,  w_dcol_nx;
    logic               r_err,   w_err_nx;

    logic               w_wr_en;
    logic [NUM_RND-1:0] w_bit;
    logic [AW-1:0]      w_wr_base;
    logic               w_beat_acc;
    logic               w_final;
    logic [ROW_W-1:0]   w_dr_row;

    assign w_wr_en    = wr_valid_i && (r_state != ST_DRAIN);
    assign w_bit      = NUM_RND'(1) << wr_round_i;
    assign w_wr_base  = AW'(wr_round_i * ROWS_PER_RND);
    assign w_beat_acc = out_valid_o && out_ready_i;
    assign w_final    = (r_drow == AW'(DEPTH - 1)) && (r_dcol == CW'(BPR - 1));

    mlp_row_ram #(
        .DATA_W       (DATA_W),
        .COLS         (COLS),
        .ROWS_PER_RND (ROWS_PER_RND),
        .DEPTH        (DEPTH),
        .AW           (AW)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (w_wr_en),
        .wr_base_i (w_wr_base),
        .wr_rows_i (wr_rows_i),
        .rd_row_i  (rd_row_i),
        .rd_data_o (rd_data_o),
        .dr_row_i  (r_drow),
        .dr_data_o (w_dr_row)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
            r_last  <= 1'b0;
            r_drow  <= '0;
            r_dcol  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_mask  <= w_mask_nx;
            r_last  <= w_last_nx;
            r_drow  <= w_drow_nx;
            r_dcol  <= w_dcol_nx;
            r_err   <= w_err_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_mask_nx  = r_mask;
        w_last_nx  = w_wr_en ? last_layer_i : r_last;
        w_drow_nx  = r_drow;
        w_dcol_nx  = r_dcol;
        w_err_nx   = r_err;
        case (r_state)
            ST_IDLE, ST_FULL: begin
                if (wr_valid_i) begin
                    w_state_nx = ST_FILL;
                    w_mask_nx  = w_bit;
                end
            end
            ST_FILL: begin
                if (wr_valid_i) w_mask_nx = r_mask | w_bit;
                // Completion is judged on the registered mask, one cycle after the last round lands.
                if (&r_mask) w_state_nx = r_last ? ST_DRAIN : ST_FULL;
            end
            ST_DRAIN: begin
                if (wr_valid_i) w_err_nx = 1'b1;
                if (w_beat_acc) begin
                    if (w_final) begin
                        w_state_nx = ST_IDLE;
                        w_drow_nx  = '0;
                        w_dcol_nx  = '0;
                    end else if (r_dcol == CW'(BPR - 1)) begin
                        w_dcol_nx = '0;
                        w_drow_nx = r_drow + AW'(1);
                    end else begin
                        w_dcol_nx = r_dcol + CW'(1);
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    assign out_valid_o = (r_state == ST_DRAIN);
    assign out_last_o  = (r_state == ST_DRAIN) && w_final;
    assign full_o      = (r_state == ST_FULL) || (r_state == ST_DRAIN);
    assign err_o       = r_err;
    assign out_data_o  = w_dr_row[r_dcol*BEAT_W +: BEAT_W];

endmodule

// File: tb/tb_mlp_act_buffer.sv
// Directed bench for mlp_act_buffer at default parameters.
module tb_mlp_act_buffer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_valid_i;
    logic [511:0] wr_rows_i;
    logic [2:0]   wr_round_i;
    logic         last_layer_i;
    logic [3:0]   rd_row_i;
    logic [255:0] rd_data_o;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [31:0]  out_data_o;
    logic         out_last_o;
    logic         full_o;
    logic         err_o;

    int nvec = 0;
    int nerr = 0;
    logic [15:0] m [16][16];

    mlp_act_buffer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid_i   (wr_valid_i),
        .wr_rows_i    (wr_rows_i),
        .wr_round_i   (wr_round_i),
        .last_layer_i (last_layer_i),
        .rd_row_i     (rd_row_i),
        .rd_data_o    (rd_data_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .out_last_o   (out_last_o),
        .full_o       (full_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pat(input int tag, input int row, input int col);
        return 16'((tag << 12) | (row << 8) | col);
    endfunction

    function automatic logic [255:0] exp_row(input int row);
        logic [255:0] v;
        for (int c = 0; c < 16; c++) v[c*16 +: 16] = m[row][c];
        return v;
    endfunction

    function automatic logic [31:0] exp_beat(input int b);
        int row, c;
        row = b / 8;
        c   = (b % 8) * 2;
        return {m[row][c+1], m[row][c]};
    endfunction

    // Drives one round for a cycle; upd mirrors it into the model when it should land.
    task automatic wr(input int rnd, input int tag, input bit last, input bit upd);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 16; c++) begin
                wr_rows_i[(r*16+c)*16 +: 16] = pat(tag, rnd*2+r, c);
                if (upd) m[rnd*2+r][c] = pat(tag, rnd*2+r, c);
            end
        wr_round_i   = 3'(rnd);
        last_layer_i = last;
        wr_valid_i   = 1'b1;
        step();
        wr_valid_i   = 1'b0;
    endtask

    initial begin
        int b, cyc;
        bit acc, pulsed;
        logic [255:0] old;
        int ooo_rnd [9] = '{7, 0, 3, 3, 1, 2, 4, 5, 6};
        int ooo_tag [9] = '{3, 3, 3, 4, 3, 3, 3, 3, 3};

        rst_n = 1'b0; wr_valid_i = 1'b0; wr_rows_i = '0; wr_round_i = '0;
        last_layer_i = 1'b0; rd_row_i = '0; out_ready_i = 1'b1;

        // Reset state
        repeat (3) step();
        chk("rst_valid", out_valid_o, 1'b0);
        chk("rst_last",  out_last_o,  1'b0);
        chk("rst_full",  full_o,      1'b0);
        chk("rst_err",   err_o,       1'b0);
        chk("rst_rdata", rd_data_o,   '0);
        rst_n = 1'b1;
        step();

        // In-order fill, not last layer
        for (int r = 0; r < 8; r++) begin
            wr(r, 1, 1'b0, 1'b1);
            chk("fill_full_early", full_o, 1'b0);
        end
        step();
        chk("fill_full", full_o, 1'b1);
        chk("fill_valid", out_valid_o, 1'b0);
        rd_row_i = 4'd5;
        step();
        chk("rd_row5", rd_data_o, exp_row(5));
        chk("rd_row5_pat", rd_data_o[15:0], 16'h1500);

        // Collision: write round 0 while reading row 0
        rd_row_i = 4'd0;
        step();
        old = exp_row(0);
        wr(0, 2, 1'b0, 1'b1);
        chk("coll_old", rd_data_o, old);
        chk("coll_full", full_o, 1'b0);
        step();
        chk("coll_new", rd_data_o, exp_row(0));

        // Out-of-order fill with duplicate round 3, last layer
        for (int i = 0; i < 9; i++) wr(ooo_rnd[i], ooo_tag[i], 1'b1, 1'b1);
        chk("ooo_err", err_o, 1'b0);
        chk("ooo_valid_early", out_valid_o, 1'b0);
        step();
        chk("ooo_valid", out_valid_o, 1'b1);
        chk("ooo_full", full_o, 1'b1);
        chk("ooo_beat0", out_data_o, {pat(3, 0, 1), pat(3, 0, 0)});
        chk("ooo_dup", m[6][0], pat(4, 6, 0));
        out_ready_i = 1'b1;
        for (int i = 0; i < 128; i++) begin
            chk("drain_valid", out_valid_o, 1'b1);
            chk("drain_data", out_data_o, exp_beat(i));
            chk("drain_last", out_last_o, (i == 127));
            step();
        end
        chk("drain_end_valid", out_valid_o, 1'b0);
        chk("drain_end_full", full_o, 1'b0);

        // Backpressure drain with a dropped write at beat 40
        for (int r = 0; r < 8; r++) wr(r, 5, 1'b1, 1'b1);
        step();
        b = 0; cyc = 0; pulsed = 0; out_ready_i = 1'b1;
        while (b < 128 && cyc < 600) begin
            chk("bp_valid", out_valid_o, 1'b1);
            chk("bp_data", out_data_o, exp_beat(b));
            chk("bp_last", out_last_o, (b == 127));
            acc = out_valid_o && out_ready_i;
            if (b == 40 && !pulsed) begin
                for (int k = 0; k < 32; k++) wr_rows_i[k*16 +: 16] = 16'hdead;
                wr_round_i = 3'd3;
                wr_valid_i = 1'b1;
                pulsed = 1;
            end else begin
                wr_valid_i = 1'b0;
            end
            step();
            if (acc) b++;
            out_ready_i = ~out_ready_i;
            cyc++;
        end
        wr_valid_i = 1'b0;
        chk("bp_count", 32'(b), 32'd128);
        chk("bp_err", err_o, 1'b1);
        chk("bp_end_valid", out_valid_o, 1'b0);

        // Reset at beat 60 of a drain
        out_ready_i = 1'b1;
        for (int r = 0; r < 8; r++) wr(r, 6, 1'b1, 1'b1);
        step();
        for (int i = 0; i < 60; i++) begin
            chk("rd_drain_data", out_data_o, exp_beat(i));
            step();
        end
        chk("pre_rst_err", err_o, 1'b1);
        chk("pre_rst_valid", out_valid_o, 1'b1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_valid", out_valid_o, 1'b0);
        chk("mid_rst_full", full_o, 1'b0);
        chk("mid_rst_err", err_o, 1'b0);
        rst_n = 1'b1;
        step();
        step();
        chk("post_rst_valid", out_valid_o, 1'b0);
        wr(2, 7, 1'b0, 1'b1);
        chk("refill_full", full_o, 1'b0);
        chk("refill_valid", out_valid_o, 1'b0);
        for (int r = 0; r < 8; r++) if (r != 2) wr(r, 7, 1'b0, 1'b1);
        step();
        chk("refill_done", full_o, 1'b1);
        chk("refill_novalid", out_valid_o, 1'b0);
        rd_row_i = 4'd4;
        step();
        chk("refill_rd4", rd_data_o, exp_row(4));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
